// File: rtl/fp_fma_special_pipe.sv
// fp_fma_special_pipe: two-stage classify/resolve of special operands for R = A*B + C
module fp_fma_special_pipe #(
  parameter int WIDTH = 32,
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter bit FTZ = 1'b0,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     C,
  input  logic [TAG_WIDTH-1:0] inTag,
  input  logic                 rmDown,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 isSpecial,
  output logic [WIDTH-1:0]     specResult,
  output logic                 invalid,
  output logic [TAG_WIDTH-1:0] outTag,
  output logic                 stickyInvalid,
  input  logic                 clrFlags
);
  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} cls_t;
  localparam logic [WIDTH-1:0] QNAN_C = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
  function automatic cls_t classify(input logic [EXP_WIDTH-1:0] e, input logic [SIG_WIDTH-1:0] f);
    return &e ? (f == '0 ? INF : f[SIG_WIDTH-1] ? QNAN : SNAN) :
           |e ? NORM : (f == '0 || FTZ) ? ZERO : SUB;
  endfunction
  logic                 s1_valid, s1_sa, s1_sb, s1_rm;
  cls_t                 s1_ca, s1_cb, s1_cc;
  logic [WIDTH-1:0]     s1_c;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 s2_load;
  logic                 sp, sc, any_snan, any_qnan, p_inf, p_zero, zero_inf, inf_cancel;
  logic                 r_spec, r_inv;
  logic [WIDTH-1:0]     r_res;
  assign s2_load = ~outValid | outReady;
  assign inReady = ~s1_valid | s2_load;
  // Rule priority is encoded by the order of the result ternary chain
  always_comb begin
    sp = s1_sa ^ s1_sb;
    sc = s1_c[WIDTH-1];
    any_snan = s1_ca == SNAN || s1_cb == SNAN || s1_cc == SNAN;
    any_qnan = s1_ca == QNAN || s1_cb == QNAN || s1_cc == QNAN;
    zero_inf = (s1_ca == INF && s1_cb == ZERO) || (s1_ca == ZERO && s1_cb == INF);
    p_inf = s1_ca == INF || s1_cb == INF;
    p_zero = s1_ca == ZERO || s1_cb == ZERO;
    inf_cancel = p_inf && s1_cc == INF && sp != sc;
    r_inv = any_snan | zero_inf | (~any_qnan & inf_cancel);
    r_spec = any_snan | any_qnan | p_inf | p_zero | (s1_cc == INF);
    r_res = (any_snan | zero_inf | any_qnan | inf_cancel) ? QNAN_C :
            p_inf ? {sp, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}} :
            s1_cc == INF ? s1_c :
            (p_zero && s1_cc == ZERO) ? {(sp == sc) ? sp : s1_rm, {(WIDTH-1){1'b0}}} :
            p_zero ? s1_c : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sa <= 1'b0;
      s1_sb <= 1'b0;
      s1_rm <= 1'b0;
      s1_ca <= ZERO;
      s1_cb <= ZERO;
      s1_cc <= ZERO;
      s1_c <= '0;
      s1_tag <= '0;
      outValid <= 1'b0;
      isSpecial <= 1'b0;
      specResult <= '0;
      invalid <= 1'b0;
      outTag <= '0;
      stickyInvalid <= 1'b0;
    end else begin
      if (inReady) begin
        s1_valid <= inValid;
        s1_sa <= A[WIDTH-1];
        s1_sb <= B[WIDTH-1];
        s1_rm <= rmDown;
        s1_ca <= classify(A[WIDTH-2 -: EXP_WIDTH], A[SIG_WIDTH-1:0]);
        s1_cb <= classify(B[WIDTH-2 -: EXP_WIDTH], B[SIG_WIDTH-1:0]);
        s1_cc <= classify(C[WIDTH-2 -: EXP_WIDTH], C[SIG_WIDTH-1:0]);
        s1_c <= C;
        s1_tag <= inTag;
      end
      if (s2_load) begin
        outValid <= s1_valid;
        isSpecial <= s1_valid & r_spec;
        specResult <= s1_valid ? r_res : '0;
        invalid <= s1_valid & r_inv;
        outTag <= s1_valid ? s1_tag : '0;
      end
      // A flag raised in the same cycle as a clear must survive
      stickyInvalid <= (outValid & outReady & invalid) | (stickyInvalid & ~clrFlags);
    end
  end
endmodule
